// File: rtl/mux_4_32_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin bus-mux arbiter.
// Contents: FSM state encoding, requester count, default tenure limit and a
// helper that turns an owner index into a one-hot grant vector.
package mux_4_32_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    localparam int N_REQ          = 4;
    localparam int DEF_MAX_TENURE = 16;

    // One-hot grant vector for a requester index.
    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_4_32_arbiter_rr_pick_4.sv
// rr_pick_4 - purely combinational round-robin picker.
// Ports:
//   req  [3:0] : request vector
//   last [1:0] : index of the previous owner
//   win  [1:0] : first asserted request scanning upward from last+1 (wrapping)
//   any        : at least one request is asserted
module rr_pick_4
    import mux_4_32_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last,
    output logic [1:0]       win,
    output logic             any
);

    logic [1:0] idx;

    // Scan from the lowest priority (last itself) toward last+1 so that the
    // final overriding hit is the highest-priority asserted request.
    always_comb begin
        win = 2'b00;
        idx = 2'b00;
        any = |req;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) begin
                win = idx;
            end else begin
                win = win;
            end
        end
    end

endmodule

// File: rtl/mux_4_32_arbiter.sv
// mux_4_32_arbiter - round-robin owner selection for a 4-input, 32-bit
// tri-state bus multiplexer, with a one-cycle float gap between owners.
// Ports:
//   clock        : rising-edge clock
//   reset        : synchronous, active-high reset
//   req    [3:0] : per-requester request, held for the whole ownership
//   grant  [3:0] : registered one-hot grant (zero when nobody owns the bus)
//   select [1:0] : registered mux select, equals the owner index
//   enable       : registered mux output enable, high only while granted
//   busy         : high whenever the FSM is not idle
// Configuration macro: TENURE_LIMIT_EN - when defined, an owner is forced off
// the bus after MAX_TENURE grant cycles if another requester is waiting.
module mux_4_32_arbiter
    import mux_4_32_arbiter_pkg::*;
#(
    parameter int MAX_TENURE = DEF_MAX_TENURE,
    parameter int TW         = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       select,
    output logic             enable,
    output logic             busy
);

    // The tenure counter must be able to hold MAX_TENURE.
    if (2 ** TW <= MAX_TENURE) begin : g_tw_check
        $error("TW too narrow for MAX_TENURE");
    end

    state_t     state;
    logic [1:0] last;
    logic [1:0] win;
    logic       any;
    logic       hand_off;

    rr_pick_4 u_pick (
        .req  (req),
        .last (last),
        .win  (win),
        .any  (any)
    );

`ifdef TENURE_LIMIT_EN
    logic [TW-1:0] tenure;
    logic          others_waiting;

    // Forced hand-off only when someone else is actually waiting.
    always_comb begin
        others_waiting = |(req & ~grant);
        if (!req[select]) begin
            hand_off = 1'b1;
        end else if ((tenure == TW'(MAX_TENURE - 1)) && others_waiting) begin
            hand_off = 1'b1;
        end else begin
            hand_off = 1'b0;
        end
    end

    // Tenure counter: cleared on entry to GRANT, saturating at MAX_TENURE.
    always_ff @(posedge clock) begin
        if (reset) begin
            tenure <= '0;
        end else if (state != ST_GRANT) begin
            tenure <= '0;
        end else if (tenure < TW'(MAX_TENURE)) begin
            tenure <= tenure + TW'(1);
        end else begin
            tenure <= tenure;
        end
    end
`else
    // Ownership ends only on voluntary release.
    always_comb begin
        if (!req[select]) begin
            hand_off = 1'b1;
        end else begin
            hand_off = 1'b0;
        end
    end
`endif

    // FSM with registered grant/select/enable and the round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            grant  <= 4'b0000;
            select <= 2'b00;
            enable <= 1'b0;
            last   <= 2'd3;
        end else begin
            case (state)
                ST_IDLE, ST_GAP: begin
                    if (any) begin
                        state  <= ST_GRANT;
                        grant  <= onehot4(win);
                        select <= win;
                        enable <= 1'b1;
                    end else begin
                        state  <= ST_IDLE;
                        grant  <= 4'b0000;
                        enable <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (hand_off) begin
                        // select is held through the gap; last rotates priority.
                        state  <= ST_GAP;
                        grant  <= 4'b0000;
                        enable <= 1'b0;
                        last   <= select;
                    end else begin
                        state  <= ST_GRANT;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    grant  <= 4'b0000;
                    select <= 2'b00;
                    enable <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
